// File: rtl/zuse_pkg.sv
// Shared tinyZuse byte-protocol definitions: command bytes, request opcodes,
// operand widths and the 3-byte operand pack/unpack helpers.
package zuse_pkg;

  localparam int E_W = 7;
  localparam int M_W = 15;

  localparam logic [7:0] CMD_SETR1  = 8'h81;
  localparam logic [7:0] CMD_SETR2  = 8'h82;
  localparam logic [7:0] CMD_READR1 = 8'h83;
  localparam logic [7:0] CMD_READR2 = 8'h84;
  localparam logic [7:0] CMD_READRS = 8'h85;
  localparam logic [7:0] CMD_ADD    = 8'h89;

  localparam logic [2:0] OP_SETR1  = 3'd0;
  localparam logic [2:0] OP_SETR2  = 3'd1;
  localparam logic [2:0] OP_READR1 = 3'd2;
  localparam logic [2:0] OP_READR2 = 3'd3;
  localparam logic [2:0] OP_READRS = 3'd4;
  localparam logic [2:0] OP_ADD    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_GAP    = 3'd2,
    ST_TXWAIT = 3'd3,
    ST_RECV   = 3'd4,
    ST_RESP   = 3'd5
  } link_state_e;

  // Wire order is byte0, byte1, byte2 from MSB to LSB of the result.
  function automatic logic [23:0] pack_operand(input logic [E_W-1:0] e, input logic [M_W-1:0] m);
    return {1'b0, e, m[14:7], m[6:0], 1'b0};
  endfunction

  function automatic logic [E_W-1:0] unpack_e(input logic [7:0] b0);
    return b0[6:0];
  endfunction

  function automatic logic [M_W-1:0] unpack_m(input logic [7:0] b1, input logic [7:0] b2);
    return {b1, b2[7:1]};
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_ADD);
  endfunction

  function automatic logic op_is_read(input logic [2:0] op);
    return (op == OP_READR1) || (op == OP_READR2) || (op == OP_READRS);
  endfunction

  function automatic logic [7:0] op_cmd(input logic [2:0] op);
    logic [7:0] cmd;
    case (op)
      OP_SETR1:  cmd = CMD_SETR1;
      OP_SETR2:  cmd = CMD_SETR2;
      OP_READR1: cmd = CMD_READR1;
      OP_READR2: cmd = CMD_READR2;
      OP_READRS: cmd = CMD_READRS;
      OP_ADD:    cmd = CMD_ADD;
      default:   cmd = 8'h00;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/zuse_link_timeout.sv
// Saturating reply-gap counter: clr loads zero, en counts up, expired flags
// the last permitted cycle (TIMEOUT_CYCLES-1).
module zuse_link_timeout #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_r;

  // Counter register; holds at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && (cnt_r != {CW{1'b1}})) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/zuse_host_link.sv
// Host-side tinyZuse UART command initiator. Define ZUSE_AUTO_READRS_EN to make
// ADD automatically follow up with READRS and return the sum.
module zuse_host_link
  import zuse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TX_GAP         = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2:0]     req_op,
  input  logic [E_W-1:0] req_e,
  input  logic [M_W-1:0] req_m,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [E_W-1:0] rsp_e,
  output logic [M_W-1:0] rsp_m,
  output logic           rsp_err,
  output logic [7:0]     tx_data,
  output logic           tx_start,
  input  logic           tx_busy,
  input  logic [7:0]     rx_data,
  input  logic           rx_done
);

  link_state_e    state_r, state_s;
  logic [1:0]     idx_r, idx_s;
  logic [7:0]     gap_r, gap_s;
  logic [2:0]     op_r, op_s;
  logic [E_W-1:0] e_r, e_s;
  logic [M_W-1:0] m_r, m_s;
  logic           auto_r, auto_s;
  logic [1:0]     rx_cnt_r, rx_cnt_s;
  logic [7:0]     rx_b0_r, rx_b0_s;
  logic [7:0]     rx_b1_r, rx_b1_s;
  logic           rsp_valid_r, rsp_valid_s;
  logic           rsp_err_r, rsp_err_s;
  logic [E_W-1:0] rsp_e_r, rsp_e_s;
  logic [M_W-1:0] rsp_m_r, rsp_m_s;
  logic [7:0]     tx_data_r, tx_data_s;
  logic           req_ready_r, req_ready_s;
  logic           tx_start_s;
  logic           tmo_clr_s, tmo_en_s, tmo_expired_s;
  logic [1:0]     last_idx_s;

  // Byte idx of the frame: 0 is the command, 1..3 the packed operand.
  function automatic logic [7:0] byte_for(input logic [2:0] op, input logic [E_W-1:0] e,
                                          input logic [M_W-1:0] m, input logic [1:0] idx,
                                          input logic auto_rs);
    logic [23:0] opnd;
    logic [7:0]  b;
    opnd = pack_operand(e, m);
    case (idx)
      2'd0:    b = auto_rs ? CMD_READRS : op_cmd(op);
      2'd1:    b = opnd[23:16];
      2'd2:    b = opnd[15:8];
      2'd3:    b = opnd[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  zuse_link_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr_s),
    .en      (tmo_en_s),
    .expired (tmo_expired_s)
  );

  // Next-state and next-output logic for the request/byte sequencer.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    gap_s       = gap_r;
    op_s        = op_r;
    e_s         = e_r;
    m_s         = m_r;
    auto_s      = auto_r;
    rx_cnt_s    = rx_cnt_r;
    rx_b0_s     = rx_b0_r;
    rx_b1_s     = rx_b1_r;
    rsp_valid_s = rsp_valid_r;
    rsp_err_s   = rsp_err_r;
    rsp_e_s     = rsp_e_r;
    rsp_m_s     = rsp_m_r;
    tx_data_s   = tx_data_r;
    tx_start_s  = 1'b0;
    tmo_clr_s   = 1'b1;
    tmo_en_s    = 1'b0;
    last_idx_s  = ((op_r == OP_SETR1) || (op_r == OP_SETR2)) ? 2'd3 : 2'd0;

    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          op_s     = req_op;
          e_s      = req_e;
          m_s      = req_m;
          idx_s    = 2'd0;
          auto_s   = 1'b0;
          rx_cnt_s = 2'd0;
          if (!op_is_legal(req_op)) begin
            state_s     = ST_RESP;
            rsp_valid_s = 1'b1;
            rsp_err_s   = 1'b1;
            rsp_e_s     = {E_W{1'b0}};
            rsp_m_s     = {M_W{1'b0}};
          end else begin
            state_s   = ST_SEND;
            tx_data_s = byte_for(req_op, req_e, req_m, 2'd0, 1'b0);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_start_s = 1'b1;
          gap_s      = 8'd0;
          state_s    = ST_GAP;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_r >= 8'(TX_GAP - 1)) begin
          state_s = ST_TXWAIT;
        end else begin
          gap_s = gap_r + 8'd1;
        end
      end
      ST_TXWAIT: begin
        if (tx_busy) begin
          state_s = ST_TXWAIT;
        end else if (idx_r != last_idx_s) begin
          idx_s     = idx_r + 2'd1;
          tx_data_s = byte_for(op_r, e_r, m_r, idx_r + 2'd1, auto_r);
          state_s   = ST_SEND;
        end else if (op_is_read(op_r) || auto_r) begin
          rx_cnt_s = 2'd0;
          state_s  = ST_RECV;
        end else begin
`ifdef ZUSE_AUTO_READRS_EN
          if (op_r == OP_ADD) begin
            auto_s    = 1'b1;
            idx_s     = 2'd0;
            tx_data_s = CMD_READRS;
            state_s   = ST_SEND;
          end else begin
            state_s     = ST_RESP;
            rsp_valid_s = 1'b1;
            rsp_err_s   = 1'b0;
            rsp_e_s     = {E_W{1'b0}};
            rsp_m_s     = {M_W{1'b0}};
          end
`else
          state_s     = ST_RESP;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b0;
          rsp_e_s     = {E_W{1'b0}};
          rsp_m_s     = {M_W{1'b0}};
`endif
        end
      end
      ST_RECV: begin
        tmo_clr_s = 1'b0;
        tmo_en_s  = 1'b1;
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (rx_done) begin
          tmo_clr_s = 1'b1;
          case (rx_cnt_r)
            2'd0: begin
              rx_b0_s  = rx_data;
              rx_cnt_s = 2'd1;
            end
            2'd1: begin
              rx_b1_s  = rx_data;
              rx_cnt_s = 2'd2;
            end
            default: begin
              state_s     = ST_RESP;
              rsp_valid_s = 1'b1;
              rsp_err_s   = 1'b0;
              rsp_e_s     = unpack_e(rx_b0_r);
              rsp_m_s     = unpack_m(rx_b1_r, rx_data);
            end
          endcase
        end else if (tmo_expired_s) begin
          state_s     = ST_RESP;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          rsp_e_s     = {E_W{1'b0}};
          rsp_m_s     = {M_W{1'b0}};
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s     = ST_IDLE;
          rsp_valid_s = 1'b0;
          rsp_err_s   = 1'b0;
          rsp_e_s     = {E_W{1'b0}};
          rsp_m_s     = {M_W{1'b0}};
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    req_ready_s = (state_s == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= 2'd0;
      gap_r       <= 8'd0;
      op_r        <= 3'd0;
      e_r         <= {E_W{1'b0}};
      m_r         <= {M_W{1'b0}};
      auto_r      <= 1'b0;
      rx_cnt_r    <= 2'd0;
      rx_b0_r     <= 8'd0;
      rx_b1_r     <= 8'd0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_e_r     <= {E_W{1'b0}};
      rsp_m_r     <= {M_W{1'b0}};
      tx_data_r   <= 8'd0;
      req_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      gap_r       <= gap_s;
      op_r        <= op_s;
      e_r         <= e_s;
      m_r         <= m_s;
      auto_r      <= auto_s;
      rx_cnt_r    <= rx_cnt_s;
      rx_b0_r     <= rx_b0_s;
      rx_b1_r     <= rx_b1_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_e_r     <= rsp_e_s;
      rsp_m_r     <= rsp_m_s;
      tx_data_r   <= tx_data_s;
      req_ready_r <= req_ready_s;
    end
  end

  // tx_start is combinational so the strobe lands the cycle after accept.
  assign tx_start  = tx_start_s;
  assign tx_data   = tx_data_r;
  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_e     = rsp_e_r;
  assign rsp_m     = rsp_m_r;

endmodule

// File: tb/tb_zuse_host_link.sv
// Directed bench for zuse_host_link with a simple uart_tx busy model.
// Honours ZUSE_AUTO_READRS_EN for the ADD scenario.
module tb_zuse_host_link;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [6:0]  req_e = 7'd0;
  logic [14:0] req_m = 15'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [6:0]  rsp_e;
  logic [14:0] rsp_m;
  logic        rsp_err;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_done = 1'b0;

  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  int n_starts = 0;
  logic [7:0] tx_log[$];

  always #50 clk = ~clk;

  zuse_host_link #(.TIMEOUT_CYCLES(TMO), .TX_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_e(req_e), .req_m(req_m),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_e(rsp_e), .rsp_m(rsp_m), .rsp_err(rsp_err),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_done(rx_done)
  );

  // uart_tx model: logs each started byte and stays busy for 5 cycles.
  always @(posedge clk) begin
    if (tx_start) begin
      tx_log.push_back(tx_data);
      n_starts <= n_starts + 1;
      busy_cnt <= 5;
      tx_busy  <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  // Called at a negedge; leaves at the negedge after the accepting edge.
  task automatic do_req(input logic [2:0] op, input logic [6:0] e, input logic [14:0] m);
    req_op = op; req_e = e; req_m = m; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at a negedge; rx_done spans exactly one posedge.
  task automatic send_rx(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string name);
    int cyc = 0;
    while (tx_log.size() < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (tx_log.size() < n) begin
      failures++;
      $display("FAIL %s tx byte count got=%0d want=%0d (timeout)", name, tx_log.size(), n);
    end
  endtask

  task automatic wait_rsp(input string name);
    int cyc = 0;
    while (!rsp_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL %s rsp_valid never asserted", name);
    end
  endtask

  task automatic ack_rsp(input string name);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_e !== 7'd0 || rsp_m !== 15'd0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ack got v=%b err=%b e=%h m=%h rdy=%b want v=0 err=0 e=0 m=0 rdy=1",
               name, rsp_valid, rsp_err, rsp_e, rsp_m, req_ready);
    end
  endtask

  task automatic check_rsp(input string name, input logic err, input logic [6:0] e, input logic [14:0] m);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== err || rsp_e !== e || rsp_m !== m) begin
      failures++;
      $display("FAIL %s rsp got v=%b err=%b e=%h m=%h want v=1 err=%b e=%h m=%h",
               name, rsp_valid, rsp_err, rsp_e, rsp_m, err, e, m);
    end
  endtask

  task automatic check_byte(input string name, input int i, input logic [7:0] want);
    logic [7:0] got;
    got = (tx_log.size() > i) ? tx_log[i] : 8'hxx;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s tx[%0d] got=%h want=%h", name, i, got, want);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_e !== 7'd0 ||
        rsp_m !== 15'd0 || tx_data !== 8'd0 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL reset got rdy=%b v=%b err=%b e=%h m=%h txd=%h txs=%b want rdy=1 rest 0",
               req_ready, rsp_valid, rsp_err, rsp_e, rsp_m, tx_data, tx_start);
    end
  endtask

  task automatic test_setr1;
    tx_log.delete();
    do_req(3'd0, 7'h3F, 15'h5555);
    checks++;
    if (tx_start !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL setr1_start got tx_start=%b req_ready=%b want 1 0", tx_start, req_ready);
    end
    wait_rsp("setr1");
    check_byte("setr1", 0, 8'h81);
    check_byte("setr1", 1, 8'h3F);
    check_byte("setr1", 2, 8'hAA);
    check_byte("setr1", 3, 8'hAA);
    check_rsp("setr1", 1'b0, 7'h00, 15'h0000);
    ack_rsp("setr1");
  endtask

  task automatic test_read;
    tx_log.delete();
    do_req(3'd3, 7'h00, 15'h0000);
    wait_tx(1, "readr2");
    repeat (12) @(negedge clk);
    send_rx(8'h45);
    send_rx(8'h80);
    send_rx(8'h03);
    check_rsp("readr2", 1'b0, 7'h45, 15'h4001);
    check_byte("readr2", 0, 8'h84);
    checks++;
    if (tx_log.size() != 1) begin
      failures++;
      $display("FAIL readr2_count got=%0d want=1", tx_log.size());
    end
    ack_rsp("readr2");
  endtask

  task automatic test_timeout;
    int cyc = 0;
    tx_log.delete();
    do_req(3'd4, 7'h00, 15'h0000);
    wait_tx(1, "readrs");
    repeat (12) @(negedge clk);
    send_rx(8'h12);
    while (!rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != TMO) begin
      failures++;
      $display("FAIL timeout_latency got=%0d want=%0d", cyc, TMO);
    end
    check_byte("readrs", 0, 8'h85);
    check_rsp("readrs_tmo", 1'b1, 7'h00, 15'h0000);
    ack_rsp("readrs");
  endtask

  task automatic test_timeout_race;
    tx_log.delete();
    do_req(3'd2, 7'h00, 15'h0000);
    wait_tx(1, "race");
    repeat (12) @(negedge clk);
    send_rx(8'hFF);
    repeat (TMO - 1) @(negedge clk);
    send_rx(8'hFF);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL race_byte_wins got rsp_valid=%b want 0", rsp_valid);
    end
    repeat (3) @(negedge clk);
    send_rx(8'hFF);
    check_rsp("race", 1'b0, 7'h7F, 15'h7FFF);
    ack_rsp("race");
  endtask

  task automatic test_illegal;
    int starts0;
    @(negedge clk);
    send_rx(8'h55);
    send_rx(8'hAA);
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_rx got rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
    end
    starts0 = n_starts;
    do_req(3'd7, 7'h11, 15'h2222);
    check_rsp("illegal", 1'b1, 7'h00, 15'h0000);
    repeat (3) @(negedge clk);
    checks++;
    if (n_starts != starts0) begin
      failures++;
      $display("FAIL illegal_no_tx got starts=%0d want=%0d", n_starts, starts0);
    end
    ack_rsp("illegal");
  endtask

  task automatic test_reset_mid;
    tx_log.delete();
    do_req(3'd1, 7'h22, 15'h1234);
    wait_tx(2, "reset_mid");
    #20;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || tx_data !== 8'd0 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got rdy=%b v=%b txd=%h txs=%b want 1 0 00 0",
               req_ready, rsp_valid, tx_data, tx_start);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    send_rx(8'h33);
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || tx_log.size() != 2) begin
      failures++;
      $display("FAIL reset_mid_quiet got v=%b txcount=%0d want 0 2", rsp_valid, tx_log.size());
    end
    tx_log.delete();
    do_req(3'd2, 7'h00, 15'h0000);
    wait_tx(1, "readr1");
    repeat (12) @(negedge clk);
    send_rx(8'h0A);
    send_rx(8'h12);
    send_rx(8'h35);
    check_byte("readr1", 0, 8'h83);
    check_rsp("readr1", 1'b0, 7'h0A, 15'h091A);
    ack_rsp("readr1");
  endtask

  task automatic test_add;
    tx_log.delete();
    do_req(3'd5, 7'h00, 15'h0000);
`ifdef ZUSE_AUTO_READRS_EN
    wait_tx(2, "add_auto");
    repeat (12) @(negedge clk);
    send_rx(8'h01);
    send_rx(8'hC0);
    send_rx(8'h00);
    check_byte("add_auto", 0, 8'h89);
    check_byte("add_auto", 1, 8'h85);
    check_rsp("add_auto", 1'b0, 7'h01, 15'h6000);
`else
    wait_rsp("add");
    check_byte("add", 0, 8'h89);
    checks++;
    if (tx_log.size() != 1) begin
      failures++;
      $display("FAIL add_count got=%0d want=1", tx_log.size());
    end
    check_rsp("add", 1'b0, 7'h00, 15'h0000);
`endif
    ack_rsp("add");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_setr1;
    test_read;
    test_timeout;
    test_timeout_race;
    test_illegal;
    test_reset_mid;
    test_add;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
